// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the ALU sequencer and its neighbours.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned CMD_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_INC = 2'b11;

  localparam logic [CMD_OP_W-1:0] CMD_LOAD = 3'b000;
  localparam logic [CMD_OP_W-1:0] CMD_ADD  = 3'b001;
  localparam logic [CMD_OP_W-1:0] CMD_SUB  = 3'b010;
  localparam logic [CMD_OP_W-1:0] CMD_AND  = 3'b011;
  localparam logic [CMD_OP_W-1:0] CMD_INC  = 3'b100;
  localparam logic [CMD_OP_W-1:0] CMD_MUL  = 3'b101;
  localparam logic [CMD_OP_W-1:0] CMD_CLR  = 3'b110;
  localparam logic [CMD_OP_W-1:0] CMD_ILL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXEC     = 2'b01,
    ST_MUL_LOOP = 2'b10,
    ST_DONE     = 2'b11
  } state_e;

  // Commands that run through the ALU map onto its opcode; everything else idles it on ADD.
  function automatic logic [ALU_OP_W-1:0] cmd_to_alu(input logic [CMD_OP_W-1:0] op);
    case (op)
      CMD_ADD: cmd_to_alu = ALU_ADD;
      CMD_SUB: cmd_to_alu = ALU_SUB;
      CMD_AND: cmd_to_alu = ALU_AND;
      CMD_INC: cmd_to_alu = ALU_INC;
      default: cmd_to_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command and response handshake channels between a host and the ALU sequencer.
interface alu_seq_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  import alu_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CMD_OP_W-1:0]   cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer owning an accumulator; drives a shared combinational ALU
// and builds MUL from repeated ADDs. All outputs come from registers loaded with next-state values.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_seq_ctrl_if.slave         bus,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_out
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CMD_OP_W-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    data_d    = data_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          if (bus.cmd_op == CMD_MUL) begin
            prod_d  = '0;
            cnt_d   = bus.cmd_data;
            mcand_d = acc_q;
            state_d = ST_MUL_LOOP;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        rsp_err_d = 1'b0;
        case (op_q)
          CMD_LOAD: acc_d = data_q;
          CMD_CLR:  acc_d = '0;
          CMD_ILL:  rsp_err_d = 1'b1;
          default:  acc_d = alu_out;
        endcase
        state_d = ST_DONE;
      end
      ST_MUL_LOOP: begin
        rsp_err_d = 1'b0;
        if (cnt_q != '0) begin
          prod_d = alu_out;
          cnt_d  = cnt_q - DATA_WIDTH'(1);
        end else begin
          acc_d   = prod_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state about to be entered.
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    rsp_data_d  = acc_d;
    alu_op_d    = ALU_ADD;
    alu_a_d     = acc_d;
    alu_b_d     = data_d;
    if (state_d == ST_EXEC) begin
      alu_op_d = cmd_to_alu(op_d);
    end else if (state_d == ST_MUL_LOOP) begin
      alu_a_d = prod_d;
      alu_b_d = mcand_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      alu_op_q    <= ALU_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      data_q      <= data_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;

endmodule
